// File: rtl/wb_stage.sv
// Writeback stage: selects ALU / PC+4 / load data and drives a one-cycle regfile write.
// Optional macro WB_SUBWORD_EN enables LB/LBU/LH/LHU extraction; otherwise loads write the raw word.
module wb_stage #(
    parameter int MEM_TIMEOUT = 16,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_wr_en,
    input  logic [1:0]      in_sel,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_funct3,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [4:0]      Rw,
    output logic            RegWr,
    output logic [XLEN-1:0] busW,
    output logic            busy,
    output logic            load_err
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        ld_rd_q, ld_rd_d;
    logic              ld_wr_q, ld_wr_d;
    logic [4:0]        rw_q, rw_d;
    logic              regwr_q, regwr_d;
    logic [XLEN-1:0]   busw_q, busw_d;
    logic              load_err_q, load_err_d;
    logic [XLEN-1:0]   load_val;

`ifdef WB_SUBWORD_EN
    logic [2:0] ld_f3_q, ld_f3_d;
    logic [1:0] ld_addr_q, ld_addr_d;

    function automatic logic [XLEN-1:0] extract_load(
        input logic [XLEN-1:0] word,
        input logic [2:0]      f3,
        input logic [1:0]      addr
    );
        logic [7:0]         b8;
        logic [15:0]        h16;
        logic signed [7:0]  b8_s;
        logic signed [15:0] h16_s;
        b8    = word[{addr, 3'b000} +: 8];
        h16   = addr[1] ? word[31:16] : word[15:0];
        b8_s  = b8;
        h16_s = h16;
        case (f3)
            3'b000:  extract_load = XLEN'(b8_s);
            3'b100:  extract_load = {{(XLEN-8){1'b0}}, b8};
            3'b001:  extract_load = XLEN'(h16_s);
            3'b101:  extract_load = {{(XLEN-16){1'b0}}, h16};
            default: extract_load = word;
        endcase
    endfunction

    assign load_val = extract_load(mem_rdata, ld_f3_q, ld_addr_q);
`else
    logic unused_funct3;
    assign unused_funct3 = ^in_funct3;
    assign load_val      = mem_rdata;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ld_rd_d    = ld_rd_q;
        ld_wr_d    = ld_wr_q;
        rw_d       = rw_q;
        busw_d     = busw_q;
        regwr_d    = 1'b0;
        load_err_d = 1'b0;
`ifdef WB_SUBWORD_EN
        ld_f3_d    = ld_f3_q;
        ld_addr_d  = ld_addr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_sel == 2'b01) begin
                        ld_rd_d = in_rd;
                        ld_wr_d = in_wr_en;
`ifdef WB_SUBWORD_EN
                        ld_f3_d   = in_funct3;
                        ld_addr_d = in_alu[1:0];
`endif
                        cnt_d   = '0;
                        state_d = WAIT_MEM;
                    end else begin
                        rw_d    = in_rd;
                        regwr_d = in_wr_en && (in_rd != 5'd0);
                        busw_d  = (in_sel == 2'b10) ? in_pc + XLEN'(4) : in_alu;
                    end
                end
            end
            WAIT_MEM: begin
                // Data arriving on the last counted cycle still wins over the timeout.
                if (mem_rvalid) begin
                    rw_d    = ld_rd_q;
                    regwr_d = ld_wr_q && (ld_rd_q != 5'd0);
                    busw_d  = load_val;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    load_err_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ld_rd_q    <= '0;
            ld_wr_q    <= 1'b0;
            rw_q       <= '0;
            regwr_q    <= 1'b0;
            busw_q     <= '0;
            load_err_q <= 1'b0;
`ifdef WB_SUBWORD_EN
            ld_f3_q    <= '0;
            ld_addr_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ld_rd_q    <= ld_rd_d;
            ld_wr_q    <= ld_wr_d;
            rw_q       <= rw_d;
            regwr_q    <= regwr_d;
            busw_q     <= busw_d;
            load_err_q <= load_err_d;
`ifdef WB_SUBWORD_EN
            ld_f3_q    <= ld_f3_d;
            ld_addr_q  <= ld_addr_d;
`endif
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == WAIT_MEM);
    assign Rw       = rw_q;
    assign RegWr    = regwr_q;
    assign busW     = busw_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; expected load values follow the WB_SUBWORD_EN build setting.
module tb_wb_stage;

`ifdef WB_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wr_en;
    logic [1:0]  in_sel;
    logic [31:0] in_alu;
    logic [31:0] in_pc;
    logic [2:0]  in_funct3;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  Rw;
    logic        RegWr;
    logic [31:0] busW;
    logic        busy;
    logic        load_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_stage #(.MEM_TIMEOUT(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_wr_en(in_wr_en), .in_sel(in_sel), .in_alu(in_alu),
        .in_pc(in_pc), .in_funct3(in_funct3), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .Rw(Rw), .RegWr(RegWr), .busW(busW),
        .busy(busy), .load_err(load_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic wr,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3);
        in_valid  = 1'b1;
        in_sel    = sel;
        in_rd     = rd;
        in_wr_en  = wr;
        in_alu    = alu;
        in_pc     = pc;
        in_funct3 = f3;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_wr_en = 1'b0; in_sel = '0;
        in_alu = '0; in_pc = '0; in_funct3 = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        #2;
        total++;
        if (RegWr !== 1'b0 || Rw !== 5'd0 || busW !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0 || load_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_init: RegWr=%b Rw=%0d busW=%h in_ready=%b busy=%b load_err=%b want 0 0 0 1 0 0",
                     RegWr, Rw, busW, in_ready, busy, load_err);
        end
        @(negedge clk);
        rst = 1'b0;
        // Write in flight, then async reset mid-cycle.
        issue(2'b00, 5'd3, 1'b1, 32'hDEAD_BEEF, 32'h0, 3'b0);
        tick;
        in_valid = 1'b0;
        total++;
        if (RegWr !== 1'b1 || busW !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL reset_pre_write: RegWr=%b busW=%h want 1 deadbeef", RegWr, busW);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (RegWr !== 1'b0 || Rw !== 5'd0 || busW !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: RegWr=%b Rw=%0d busW=%h in_ready=%b busy=%b want 0 0 0 1 0",
                     RegWr, Rw, busW, in_ready, busy);
        end
        #2 rst = 1'b0;
    endtask

    task automatic test_alu;
        issue(2'b00, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 3'b0);
        tick;
        in_valid = 1'b0;
        total++;
        if (RegWr !== 1'b1 || Rw !== 5'd5 || busW !== 32'h1234_5678) begin
            bad++;
            $display("FAIL alu_write: RegWr=%b Rw=%0d busW=%h want 1 5 12345678", RegWr, Rw, busW);
        end
        tick;
        total++;
        if (RegWr !== 1'b0 || busW !== 32'h1234_5678 || Rw !== 5'd5) begin
            bad++;
            $display("FAIL alu_pulse_end: RegWr=%b Rw=%0d busW=%h want 0 5 12345678", RegWr, Rw, busW);
        end
        // sel=11 behaves as ALU; wr_en=0 suppresses the write but data still updates.
        issue(2'b11, 5'd2, 1'b1, 32'hCAFE_F00D, 32'h100, 3'b0);
        tick;
        total++;
        if (RegWr !== 1'b1 || Rw !== 5'd2 || busW !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL sel11: RegWr=%b Rw=%0d busW=%h want 1 2 cafef00d", RegWr, Rw, busW);
        end
        issue(2'b00, 5'd4, 1'b0, 32'h0000_0044, 32'h0, 3'b0);
        tick;
        in_valid = 1'b0;
        total++;
        if (RegWr !== 1'b0 || Rw !== 5'd4 || busW !== 32'h0000_0044) begin
            bad++;
            $display("FAIL wr_en_off: RegWr=%b Rw=%0d busW=%h want 0 4 00000044", RegWr, Rw, busW);
        end
    endtask

    task automatic test_back_to_back;
        issue(2'b00, 5'd9, 1'b1, 32'hAAAA_0001, 32'h0, 3'b0);
        tick;
        total++;
        if (RegWr !== 1'b1 || Rw !== 5'd9 || busW !== 32'hAAAA_0001) begin
            bad++;
            $display("FAIL b2b_first: RegWr=%b Rw=%0d busW=%h want 1 9 aaaa0001", RegWr, Rw, busW);
        end
        issue(2'b10, 5'd10, 1'b1, 32'h0, 32'h0000_1000, 3'b0);
        tick;
        in_valid = 1'b0;
        total++;
        if (RegWr !== 1'b1 || Rw !== 5'd10 || busW !== 32'h0000_1004) begin
            bad++;
            $display("FAIL b2b_second: RegWr=%b Rw=%0d busW=%h want 1 10 00001004", RegWr, Rw, busW);
        end
        tick;
        total++;
        if (RegWr !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: RegWr=%b want 0", RegWr);
        end
    endtask

    task automatic test_pc4;
        issue(2'b10, 5'd1, 1'b1, 32'h0000_0055, 32'hFFFF_FFFC, 3'b0);
        tick;
        in_valid = 1'b0;
        total++;
        if (RegWr !== 1'b1 || Rw !== 5'd1 || busW !== 32'h0000_0000) begin
            bad++;
            $display("FAIL pc4_wrap: RegWr=%b Rw=%0d busW=%h want 1 1 00000000", RegWr, Rw, busW);
        end
    endtask

    task automatic test_load_lb;
        logic [31:0] exp;
        exp = SUB ? 32'hFFFF_FF80 : 32'h80AA_BBCC;
        issue(2'b01, 5'd7, 1'b1, 32'h0000_1003, 32'h0, 3'b000);
        tick;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || RegWr !== 1'b0) begin
            bad++;
            $display("FAIL lb_wait1: busy=%b in_ready=%b RegWr=%b want 1 0 0", busy, in_ready, RegWr);
        end
        tick;
        tick;
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || RegWr !== 1'b0 || load_err !== 1'b0) begin
            bad++;
            $display("FAIL lb_wait3: busy=%b in_ready=%b RegWr=%b load_err=%b want 1 0 0 0",
                     busy, in_ready, RegWr, load_err);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80AA_BBCC;
        // Next instruction presented right away; it is only taken once back in IDLE.
        issue(2'b00, 5'd11, 1'b1, 32'h0BAD_CAFE, 32'h0, 3'b0);
        tick;
        mem_rvalid = 1'b0;
        total++;
        if (RegWr !== 1'b1 || Rw !== 5'd7 || busW !== exp || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL lb_write: RegWr=%b Rw=%0d busW=%h busy=%b in_ready=%b want 1 7 %h 0 1",
                     RegWr, Rw, busW, busy, in_ready, exp);
        end
        tick;
        in_valid = 1'b0;
        total++;
        if (RegWr !== 1'b1 || Rw !== 5'd11 || busW !== 32'h0BAD_CAFE) begin
            bad++;
            $display("FAIL load_then_alu: RegWr=%b Rw=%0d busW=%h want 1 11 0badcafe", RegWr, Rw, busW);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        tick;
        mem_rvalid = 1'b0;
        total++;
        if (RegWr !== 1'b0 || busW !== 32'h0BAD_CAFE || busy !== 1'b0) begin
            bad++;
            $display("FAIL rvalid_idle: RegWr=%b busW=%h busy=%b want 0 0badcafe 0", RegWr, busW, busy);
        end
    endtask

    task automatic test_subword;
        logic [2:0]  f3   [5] = '{3'b101, 3'b101, 3'b001, 3'b100, 3'b010};
        logic [1:0]  addr [5] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
        logic [4:0]  rd   [5] = '{5'd8, 5'd0, 5'd12, 5'd13, 5'd14};
        logic [31:0] word [5] = '{32'h9ABC_1234, 32'h9ABC_1234, 32'h1234_8001, 32'h0000_F000, 32'hFEDC_BA98};
        logic [31:0] esub [5] = '{32'h0000_9ABC, 32'h0000_9ABC, 32'hFFFF_8001, 32'h0000_00F0, 32'hFEDC_BA98};
        logic [31:0] exp;
        logic        exp_wr;
        for (int i = 0; i < 5; i++) begin
            exp    = SUB ? esub[i] : word[i];
            exp_wr = (rd[i] != 5'd0);
            issue(2'b01, rd[i], 1'b1, {28'h0000_100, 2'b00, addr[i]}, 32'h0, f3[i]);
            tick;
            in_valid   = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = word[i];
            tick;
            mem_rvalid = 1'b0;
            total++;
            if (RegWr !== exp_wr || Rw !== rd[i] || busW !== exp) begin
                bad++;
                $display("FAIL subword_%0d: RegWr=%b Rw=%0d busW=%h want %b %0d %h",
                         i, RegWr, Rw, busW, exp_wr, rd[i], exp);
            end
        end
    endtask

    task automatic test_timeout;
        logic [31:0] held;
        held = busW;
        issue(2'b01, 5'd6, 1'b1, 32'h0000_2000, 32'h0, 3'b010);
        tick;
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick;
            if (i < 4) begin
                total++;
                if (load_err !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL timeout_wait_%0d: load_err=%b busy=%b want 0 1", i, load_err, busy);
                end
            end
        end
        total++;
        if (load_err !== 1'b1 || RegWr !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err: load_err=%b RegWr=%b in_ready=%b busy=%b want 1 0 1 0",
                     load_err, RegWr, in_ready, busy);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        tick;
        mem_rvalid = 1'b0;
        total++;
        if (load_err !== 1'b0 || RegWr !== 1'b0 || busW !== held) begin
            bad++;
            $display("FAIL timeout_late: load_err=%b RegWr=%b busW=%h want 0 0 %h", load_err, RegWr, busW, held);
        end
    endtask

    task automatic test_reset_wait;
        issue(2'b01, 5'd15, 1'b1, 32'h0000_3000, 32'h0, 3'b010);
        tick;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || RegWr !== 1'b0) begin
            bad++;
            $display("FAIL reset_wait: busy=%b in_ready=%b RegWr=%b want 0 1 0", busy, in_ready, RegWr);
        end
        #2 rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        tick;
        mem_rvalid = 1'b0;
        total++;
        if (RegWr !== 1'b0 || busW !== 32'd0 || Rw !== 5'd0) begin
            bad++;
            $display("FAIL reset_wait_late: RegWr=%b busW=%h Rw=%0d want 0 0 0", RegWr, busW, Rw);
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_back_to_back;
        test_pc4;
        test_load_lb;
        test_subword;
        test_timeout;
        test_reset_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
